// File: rtl/sprite_plane.sv
// sprite_plane: one double-buffered, scalable sprite layer. Raster coordinates go in, and a
// 32-bit colour comes out four clocks later. A colour of 0 means transparent.
// The pipeline is S1 offset, S2 bounds/address, S3 bitmap read, S4 palette read,
// followed by the output register.
module sprite_plane #(
  parameter int SPRITE_BITS = 5
) (
  input  logic               clkv,
  input  logic               resetv,
  input  logic signed [31:0] count_h,
  input  logic signed [31:0] count_v,
  output logic signed [31:0] color,
  input  logic               we,
  input  logic        [15:0] addr,
  input  logic        [31:0] wdata
);

  localparam int Size = 1 << SPRITE_BITS;
  localparam int Aw   = 2 * SPRITE_BITS;

  logic signed [31:0] x_sh_q, y_sh_q, x_act_q, y_act_q;
  logic        [1:0]  scale_sh_q, scale_act_q;
  logic               en_sh_q, en_act_q;

  logic               strobe;
  logic signed [31:0] x_use, y_use;
  logic        [1:0]  scale_use;
  logic               en_use;

  logic signed [32:0] dh_q, dv_q;
  logic        [1:0]  scale1_q;
  logic               en1_q;

  logic        [32:0] extent;
  logic signed [32:0] dh_shr, dv_shr;
  logic               inside_d;
  logic     [Aw-1:0]  baddr_d;

  logic               inside2_q, inside3_q, inside4_q, nz4_q;
  logic     [Aw-1:0]  baddr_q;
  logic        [7:0]  idx_q;
  logic        [31:0] pal_q;

  logic        [7:0]  bmp_mem [2**Aw];
  logic        [31:0] pal_mem [256];

  logic               unused_ok;

  // The strobe pixel already sees the values that are being latched on this edge.
  always_comb begin
    strobe    = (count_h == 32'sd0) && (count_v == 32'sd0);
    x_use     = strobe ? x_sh_q     : x_act_q;
    y_use     = strobe ? y_sh_q     : y_act_q;
    scale_use = strobe ? scale_sh_q : scale_act_q;
    en_use    = strobe ? en_sh_q    : en_act_q;
  end

  // Writes go to the shadow registers. Active copies take the pre-write shadow at frame start.
  always_ff @(posedge clkv) begin
    if (resetv) begin
      x_sh_q      <= '0;
      y_sh_q      <= '0;
      scale_sh_q  <= '0;
      en_sh_q     <= 1'b0;
      x_act_q     <= '0;
      y_act_q     <= '0;
      scale_act_q <= '0;
      en_act_q    <= 1'b0;
    end else begin
      if (strobe) begin
        x_act_q     <= x_sh_q;
        y_act_q     <= y_sh_q;
        scale_act_q <= scale_sh_q;
        en_act_q    <= en_sh_q;
      end
      if (we && addr[15:14] == 2'b00) begin
        unique case (addr[1:0])
          2'd0: x_sh_q     <= $signed(wdata);
          2'd1: y_sh_q     <= $signed(wdata);
          2'd2: scale_sh_q <= wdata[1:0];
          2'd3: en_sh_q    <= wdata[0];
        endcase
      end
    end
  end

  // S1: compute the offset from the sprite origin at full 33-bit width so it cannot wrap.
  always_ff @(posedge clkv) begin
    if (resetv) begin
      dh_q     <= '0;
      dv_q     <= '0;
      scale1_q <= '0;
      en1_q    <= 1'b0;
    end else begin
      dh_q     <= {count_h[31], count_h} - {x_use[31], x_use};
      dv_q     <= {count_v[31], count_v} - {y_use[31], y_use};
      scale1_q <= scale_use;
      en1_q    <= en_use;
    end
  end

  // S2: do the bounds test and form the source pixel address.
  always_comb begin
    extent   = 33'(Size) << scale1_q;
    dh_shr   = dh_q >>> scale1_q;
    dv_shr   = dv_q >>> scale1_q;
    inside_d = en1_q && !dh_q[32] && !dv_q[32] &&
               ($unsigned(dh_q) < extent) && ($unsigned(dv_q) < extent);
    baddr_d  = {dv_shr[SPRITE_BITS-1:0], dh_shr[SPRITE_BITS-1:0]};
  end

  // Pipeline valid flags and the bitmap address register.
  always_ff @(posedge clkv) begin
    if (resetv) begin
      inside2_q <= 1'b0;
      inside3_q <= 1'b0;
      inside4_q <= 1'b0;
      nz4_q     <= 1'b0;
      baddr_q   <= '0;
    end else begin
      inside2_q <= inside_d;
      inside3_q <= inside2_q;
      inside4_q <= inside3_q;
      nz4_q     <= (idx_q != 8'd0);
      baddr_q   <= baddr_d;
    end
  end

  // S3: bitmap RAM. A read in the same cycle as a write to that entry returns the old data.
  always_ff @(posedge clkv) begin
    if (we && addr[15]) bmp_mem[addr[Aw-1:0]] <= wdata[7:0];
    idx_q <= bmp_mem[baddr_q];
  end

  // S4: palette RAM, also read-before-write.
  always_ff @(posedge clkv) begin
    if (we && addr[15:14] == 2'b01) pal_mem[addr[7:0]] <= wdata;
    pal_q <= pal_mem[idx_q];
  end

  // Output register. Index 0 is forced transparent.
  always_ff @(posedge clkv) begin
    if (resetv) begin
      color <= '0;
    end else begin
      color <= (inside4_q && nz4_q) ? $signed(pal_q) : 32'sd0;
    end
  end

  assign unused_ok = ^{addr, wdata, dh_shr, dv_shr};

endmodule

// File: tb/tb_sprite_plane.sv
// Scoreboard bench for sprite_plane. Each cycle pushes the colour a reference model expects,
// and the entry that is four cycles old is compared against the DUT output.
module tb_sprite_plane;

  localparam int Sb   = 5;
  localparam int Size = 1 << Sb;
  localparam int Lat  = 4;

  logic               clkv = 1'b0;
  logic               resetv = 1'b1;
  logic signed [31:0] count_h = '0;
  logic signed [31:0] count_v = '0;
  logic signed [31:0] color;
  logic               we = 1'b0;
  logic        [15:0] addr = '0;
  logic        [31:0] wdata = '0;

  always #5 clkv = ~clkv;

  sprite_plane #(.SPRITE_BITS(Sb)) dut (
    .clkv    (clkv),
    .resetv  (resetv),
    .count_h (count_h),
    .count_v (count_v),
    .color   (color),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata)
  );

  // Reference model state
  logic [7:0]  m_bmp [Size*Size];
  logic [31:0] m_pal [256];
  int          m_x_sh = 0, m_y_sh = 0, m_sc_sh = 0, m_x = 0, m_y = 0, m_sc = 0;
  bit          m_en_sh = 0, m_en = 0;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    int          h;
    int          v;
  } ent_t;
  ent_t sb_q[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] model_pix(input int h, input int v);
    longint dh, dv, ext;
    int col, row;
    logic [7:0] idx;
    dh  = longint'(h) - longint'(m_x);
    dv  = longint'(v) - longint'(m_y);
    ext = longint'(Size) << m_sc;
    if (!m_en || dh < 0 || dv < 0 || dh >= ext || dv >= ext) return 32'h0;
    col = int'(dh >> m_sc);
    row = int'(dv >> m_sc);
    idx = m_bmp[row * Size + col];
    if (idx == 8'd0) return 32'h0;
    return m_pal[idx];
  endfunction

  // One clock: drive the inputs, update the model, push the expected colour, and check the
  // entry that is four cycles old.
  task automatic step(input int h, input int v, input bit chk, input bit w = 0,
                      input logic [15:0] a = 16'h0, input logic [31:0] d = 32'h0,
                      input bit rst = 0);
    ent_t e;
    count_h = h;
    count_v = v;
    we      = w;
    addr    = a;
    wdata   = d;
    resetv  = rst;
    if (rst) begin
      m_x_sh = 0; m_y_sh = 0; m_sc_sh = 0; m_en_sh = 0;
      m_x = 0; m_y = 0; m_sc = 0; m_en = 0;
      foreach (sb_q[i]) begin
        sb_q[i].chk = 1'b1;
        sb_q[i].exp = 32'h0;
      end
    end else begin
      if (h == 0 && v == 0) begin
        m_x = m_x_sh; m_y = m_y_sh; m_sc = m_sc_sh; m_en = m_en_sh;
      end
      if (w && a[15:14] == 2'b00) begin
        case (a[1:0])
          2'd0: m_x_sh = int'(d);
          2'd1: m_y_sh = int'(d);
          2'd2: m_sc_sh = int'(d[1:0]);
          default: m_en_sh = d[0];
        endcase
      end
    end
    if (w && a[15:14] == 2'b01) m_pal[a[7:0]] = d;
    if (w && a[15]) m_bmp[a[2*Sb-1:0]] = d[7:0];
    if (rst) sb_q.push_back('{chk: 1'b1, exp: 32'h0, h: h, v: v});
    else sb_q.push_back('{chk: chk, exp: model_pix(h, v), h: h, v: v});
    @(posedge clkv);
    #1;
    if (sb_q.size() > Lat) begin
      e = sb_q.pop_front();
      if (e.chk) begin
        checks++;
        if (color !== e.exp) begin
          errors++;
          $display("FAIL pixel(%0d,%0d) color=%h expected=%h", e.h, e.v, color, e.exp);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1000, 1000, 0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    step(1000, 1000, 0, 1, a, d);
  endtask

  task automatic test_reset;
    step(1000, 1000, 0, 0, 16'h0, 32'h0, 1);
    checks++;
    if (color !== 32'h0) begin
      errors++;
      $display("FAIL reset_color color=%h expected=0", color);
    end
    step(1000, 1000, 0, 0, 16'h0, 32'h0, 1);
    idle(Lat + 1);
  endtask

  task automatic init_mem;
    for (int i = 0; i < Size * Size; i++) wr(16'h8000 | 16'(i), 32'h0);
    for (int i = 0; i < 256; i++) wr(16'h4000 | 16'(i), 32'h0);
  endtask

  task automatic test_basic;
    wr(16'h0000, 32'd100);
    wr(16'h0001, 32'd50);
    wr(16'h0002, 32'd0);
    wr(16'h0003, 32'd1);
    wr(16'h8000, 32'd7);
    wr(16'h4007, 32'h00FF0000);
    step(0, 0, 0);
    step(100, 50, 1);
    step(99, 50, 1);
    step(132, 50, 1);
    step(100, 50, 1);
    step(100, 49, 1);
    step(100, 82, 1);
    idle(Lat + 1);
  endtask

  task automatic test_transparency;
    wr(16'h8001, 32'd0);
    wr(16'h4000, 32'h12345678);
    wr(16'h8002, 32'd5);
    wr(16'h4005, 32'h0);
    step(101, 50, 1);
    step(102, 50, 1);
    step(100, 50, 1);
    idle(Lat + 1);
  endtask

  task automatic test_scale;
    wr(16'h0002, 32'd2);
    wr(16'h8001, 32'd3);
    wr(16'h4003, 32'h000000AB);
    wr(16'h801F, 32'd7);
    wr(16'h8000 | 16'(31 * Size), 32'd3);
    step(0, 0, 0);
    for (int h = 103; h <= 108; h++) step(h, 50, 1);
    step(227, 50, 1);
    step(228, 50, 1);
    step(100, 177, 1);
    step(100, 178, 1);
    idle(Lat + 1);
  endtask

  task automatic test_double_buffer;
    wr(16'h0002, 32'd0);
    step(0, 0, 0);
    step(100, 50, 1);
    step(100, 50, 1, 1, 16'h0000, 32'd200);
    step(100, 50, 1);
    step(200, 50, 1);
    step(0, 0, 0);
    step(200, 50, 1);
    step(100, 50, 1);
    wr(16'h0000, 32'd100);
    step(0, 0, 0, 1, 16'h0000, 32'd200);
    step(100, 50, 1);
    step(200, 50, 1);
    step(0, 0, 0);
    step(200, 50, 1);
    step(100, 50, 1);
    idle(Lat + 1);
  endtask

  task automatic test_clip;
    wr(16'h0000, 32'hFFFF_FFF6);
    wr(16'h800A, 32'd9);
    wr(16'h4009, 32'h00000099);
    step(0, 0, 0);
    step(0, 50, 1);
    step(-10, 50, 1);
    step(-11, 50, 1);
    step(21, 50, 1);
    step(22, 50, 1);
    wr(16'h0000, 32'h7FFF_FFF0);
    step(0, 0, 0);
    step(-5, 50, 1);
    step(-2147483643, 50, 1);
    step(2147483632, 50, 1);
    step(2147483642, 50, 1);
    idle(Lat + 1);
  endtask

  task automatic test_reset_mid;
    wr(16'h0000, 32'd100);
    wr(16'h0001, 32'd50);
    step(0, 0, 0);
    step(100, 50, 1);
    step(100, 50, 1);
    step(100, 50, 1);
    step(100, 50, 1, 0, 16'h0, 32'h0, 1);
    repeat (Lat) step(100, 50, 1);
    step(0, 0, 0);
    step(100, 50, 1);
    wr(16'h0000, 32'd100);
    wr(16'h0001, 32'd50);
    wr(16'h0003, 32'd1);
    step(100, 50, 1);
    step(0, 0, 0);
    step(100, 50, 1);
    step(101, 51, 1);
    idle(Lat + 1);
  endtask

  initial begin
    test_reset();
    init_mem();
    test_basic();
    test_transparency();
    test_scale();
    test_double_buffer();
    test_clip();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
